// File: rtl/spi_flash_responder.sv
// SPI-flash read target: READ 0x03, JEDEC ID 0x9F, RDSR 0x05, all pins oversampled in the clk domain.
// Define SPI_FLASH_RESP_FAST_READ_EN to also accept FAST READ 0x0B (24-bit address + 8 dummy clocks).
module spi_flash_responder #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter logic [23:0] JEDEC_ID   = 24'hEF4016
) (
    input  logic                  clk,
    input  logic                  rst_ni,
    input  logic                  cs_n_i,
    input  logic                  sck_i,
    input  logic                  mosi_i,
    output logic                  miso_o,
    output logic                  miso_oe_o,
    output logic                  mem_rd_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [7:0]            mem_data_i,
    output logic                  busy_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_ID, S_SR, S_IGNORE
    } state_t;

    state_t                state;
    logic [1:0]            cs_sync;
    logic                  cs_d;
    logic [2:0]            sck_sync;
    logic [1:0]            mosi_sync;
    logic [4:0]            bit_cnt;
    logic [6:0]            cmd_sh;
    logic [ADDR_WIDTH-2:0] addr_sh;
    logic [7:0]            byte_sh;
    logic [1:0]            id_idx;
    logic [7:0]            id_byte_c;
`ifdef SPI_FLASH_RESP_FAST_READ_EN
    logic                  fast;
`endif

    logic cs_fall_c, cs_rise_c, sck_rise_c, sck_fall_c, mosi_c, tx_state_c;
    assign cs_fall_c  = cs_d & ~cs_sync[1];
    assign cs_rise_c  = ~cs_d & cs_sync[1];
    assign sck_rise_c = sck_sync[1] & ~sck_sync[2];
    assign sck_fall_c = ~sck_sync[1] & sck_sync[2];
    assign mosi_c     = mosi_sync[1];
    assign tx_state_c = (state == S_DATA) || (state == S_ID) || (state == S_SR);

    // Next JEDEC byte to present; zero once all three ID bytes are out.
    always_comb begin
        id_byte_c = 8'h00;
        case (id_idx)
            2'd0:    id_byte_c = JEDEC_ID[23:16];
            2'd1:    id_byte_c = JEDEC_ID[15:8];
            2'd2:    id_byte_c = JEDEC_ID[7:0];
            default: id_byte_c = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            // CS sync resets as "selected" so a CS held low through reset is not seen as a fresh fall
            cs_sync    <= '0;
            cs_d       <= 1'b0;
            sck_sync   <= '0;
            mosi_sync  <= '0;
            state      <= S_IDLE;
            bit_cnt    <= '0;
            cmd_sh     <= '0;
            addr_sh    <= '0;
            byte_sh    <= '0;
            id_idx     <= '0;
            miso_o     <= 1'b0;
            miso_oe_o  <= 1'b0;
            mem_rd_o   <= 1'b0;
            mem_addr_o <= '0;
            busy_o     <= 1'b0;
`ifdef SPI_FLASH_RESP_FAST_READ_EN
            fast       <= 1'b0;
`endif
        end else begin
            cs_sync   <= {cs_sync[0], cs_n_i};
            cs_d      <= cs_sync[1];
            sck_sync  <= {sck_sync[1:0], sck_i};
            mosi_sync <= {mosi_sync[0], mosi_i};
            mem_rd_o  <= 1'b0;

            if (cs_rise_c) begin
                state     <= S_IDLE;
                bit_cnt   <= '0;
                miso_o    <= 1'b0;
                miso_oe_o <= 1'b0;
                busy_o    <= 1'b0;
            end else begin
                // Fetched byte lands one clk after the strobe; bit 7 goes out at once
                if (mem_rd_o && (state == S_DATA || state == S_DUMMY)) begin
                    byte_sh <= mem_data_i;
                    miso_o  <= mem_data_i[7];
                end
                // Mode 0: advance on SCK fall; the fall right after a byte boundary keeps bit 7
                if (sck_fall_c && tx_state_c && bit_cnt != 5'd0) begin
                    miso_o <= byte_sh[3'(5'd7 - bit_cnt)];
                end

                case (state)
                    S_IDLE: if (cs_fall_c) begin
                        state   <= S_CMD;
                        bit_cnt <= '0;
                        cmd_sh  <= '0;
                        busy_o  <= 1'b1;
`ifdef SPI_FLASH_RESP_FAST_READ_EN
                        fast    <= 1'b0;
`endif
                    end
                    S_CMD: if (sck_rise_c) begin
                        cmd_sh  <= {cmd_sh[5:0], mosi_c};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt <= '0;
                            case ({cmd_sh, mosi_c})
                                8'h03: state <= S_ADDR;
                                8'h9F: begin
                                    state     <= S_ID;
                                    miso_oe_o <= 1'b1;
                                    byte_sh   <= JEDEC_ID[23:16];
                                    miso_o    <= JEDEC_ID[23];
                                    id_idx    <= 2'd1;
                                end
                                8'h05: begin
                                    state     <= S_SR;
                                    miso_oe_o <= 1'b1;
                                    byte_sh   <= 8'h00;
                                    miso_o    <= 1'b0;
                                end
`ifdef SPI_FLASH_RESP_FAST_READ_EN
                                8'h0B: begin
                                    state <= S_ADDR;
                                    fast  <= 1'b1;
                                end
`endif
                                default: state <= S_IGNORE;
                            endcase
                        end
                    end
                    S_ADDR: if (sck_rise_c) begin
                        addr_sh <= {addr_sh[ADDR_WIDTH-3:0], mosi_c};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd23) begin
                            bit_cnt    <= '0;
                            mem_addr_o <= {addr_sh, mosi_c};
                            mem_rd_o   <= 1'b1;
                            state      <= S_DATA;
                            miso_oe_o  <= 1'b1;
`ifdef SPI_FLASH_RESP_FAST_READ_EN
                            if (fast) begin
                                state     <= S_DUMMY;
                                miso_oe_o <= 1'b0;
                            end
`endif
                        end
                    end
`ifdef SPI_FLASH_RESP_FAST_READ_EN
                    S_DUMMY: if (sck_rise_c) begin
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt   <= '0;
                            state     <= S_DATA;
                            miso_oe_o <= 1'b1;
                        end
                    end
`endif
                    S_DATA: if (sck_rise_c) begin
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt    <= '0;
                            mem_addr_o <= mem_addr_o + ADDR_WIDTH'(1);
                            mem_rd_o   <= 1'b1;
                        end
                    end
                    S_ID: if (sck_rise_c) begin
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt <= '0;
                            byte_sh <= id_byte_c;
                            miso_o  <= id_byte_c[7];
                            if (id_idx != 2'd3) id_idx <= id_idx + 2'd1;
                        end
                    end
                    S_SR: if (sck_rise_c) begin
                        bit_cnt <= (bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: bit-banged SPI master, array-backed memory, queue of observed strobes.
`timescale 1ns/1ps
module tb_spi_flash_responder;

    localparam int HALF  = 6;
    localparam int SETUP = 6;
    localparam int GAP   = 10;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b1;
    logic        cs_n = 1'b1;
    logic        sck = 1'b0;
    logic        mosi = 1'b0;
    logic        miso, miso_oe, mem_rd, busy;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data = 8'h00;

    logic [7:0]  mem [0:65535];
    logic [7:0]  tx_buf [0:7];
    logic [7:0]  rx_buf [0:7];
    logic [7:0]  oe_buf [0:7];
    logic        busy_all, busy_any;
    int unsigned strobe_q[$];
    int          total = 0;
    int          bad = 0;

    spi_flash_responder #(.ADDR_WIDTH(16), .JEDEC_ID(24'hEF4016)) dut (
        .clk(clk), .rst_ni(rst_ni), .cs_n_i(cs_n), .sck_i(sck), .mosi_i(mosi),
        .miso_o(miso), .miso_oe_o(miso_oe), .mem_rd_o(mem_rd), .mem_addr_o(mem_addr),
        .mem_data_i(mem_data), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Memory answers one clk after each strobe; garbage otherwise so late/early loads show up
    always @(negedge clk) begin
        if (mem_rd === 1'b1) begin
            strobe_q.push_back(32'(mem_addr));
            mem_data = mem[mem_addr];
        end else begin
            mem_data = 8'($urandom);
        end
    end

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_txn(input int nbits, input bit keep_cs);
        strobe_q.delete();
        busy_all = 1'b1;
        busy_any = 1'b0;
        for (int j = 0; j < 8; j++) begin
            rx_buf[j] = '0;
            oe_buf[j] = '0;
        end
        cs_n = 1'b0;
        clk_wait(SETUP);
        for (int i = 0; i < nbits; i++) begin
            int b;
            int k;
            b = i / 8;
            k = 7 - (i % 8);
            mosi = tx_buf[b][k];
            clk_wait(HALF);
            sck = 1'b1;
            rx_buf[b][k] = miso;
            oe_buf[b][k] = miso_oe;
            busy_all &= busy;
            busy_any |= busy;
            clk_wait(HALF);
            sck = 1'b0;
        end
        clk_wait(HALF);
        if (!keep_cs) begin
            cs_n = 1'b1;
            clk_wait(GAP);
        end
    endtask

    task automatic read_and_check(input logic [23:0] addr, input int n, input string tag);
        tx_buf[0] = 8'h03;
        tx_buf[1] = addr[23:16];
        tx_buf[2] = addr[15:8];
        tx_buf[3] = addr[7:0];
        for (int j = 4; j < 8; j++) tx_buf[j] = 8'($urandom);
        run_txn(32 + 8 * n, 1'b0);
        for (int k = 0; k < n; k++) begin
            logic [7:0] exp_b;
            exp_b = mem[16'(addr[15:0] + 16'(k))];
            total++;
            if (rx_buf[4 + k] !== exp_b) begin
                bad++;
                $display("FAIL %s byte%0d: got %h expected %h", tag, k, rx_buf[4 + k], exp_b);
            end
            total++;
            if (oe_buf[4 + k] !== 8'hFF) begin
                bad++;
                $display("FAIL %s oe byte%0d: got %b expected 11111111", tag, k, oe_buf[4 + k]);
            end
        end
        total++;
        if ({oe_buf[0], oe_buf[1], oe_buf[2], oe_buf[3]} !== 32'h0 || busy_all !== 1'b1) begin
            bad++;
            $display("FAIL %s hdr: got oe=%h%h%h%h busy_all=%b expected oe=0 busy_all=1",
                     tag, oe_buf[0], oe_buf[1], oe_buf[2], oe_buf[3], busy_all);
        end
        total++;
        if (strobe_q.size() != n + 1) begin
            bad++;
            $display("FAIL %s strobes: got %0d expected %0d", tag, strobe_q.size(), n + 1);
        end else begin
            for (int k = 0; k <= n; k++) begin
                int unsigned exp_a;
                exp_a = 32'(16'(addr[15:0] + 16'(k)));
                total++;
                if (strobe_q[k] !== exp_a) begin
                    bad++;
                    $display("FAIL %s strobe%0d: got %h expected %h", tag, k, strobe_q[k], exp_a);
                end
            end
        end
        total++;
        if (miso_oe !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s release: got oe=%b busy=%b expected 0 0", tag, miso_oe, busy);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        cs_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sck = ~sck;
            mosi = 1'($urandom);
            clk_wait(3);
        end
        sck = 1'b0;
        total++;
        if ({miso, miso_oe, mem_rd, busy} !== 4'b0 || mem_addr !== 16'h0) begin
            bad++;
            $display("FAIL reset_out: got miso=%b oe=%b rd=%b busy=%b addr=%h expected zeros",
                     miso, miso_oe, mem_rd, busy, mem_addr);
        end
        rst_ni = 1'b1;
        clk_wait(4);
        tx_buf[0] = 8'h03; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00; tx_buf[3] = 8'h10;
        tx_buf[4] = 8'h00; tx_buf[5] = 8'h00;
        run_txn(48, 1'b1);
        total++;
        if (strobe_q.size() != 0 || busy_any !== 1'b0 || oe_buf[4] !== 8'h0) begin
            bad++;
            $display("FAIL reset_cs_low: got strobes=%0d busy_any=%b oe=%h expected 0 0 00",
                     strobe_q.size(), busy_any, oe_buf[4]);
        end
        cs_n = 1'b1;
        clk_wait(GAP);
    endtask

    task automatic test_read_basic();
        mem[16'h0010] = 8'hA5;
        mem[16'h0011] = 8'h3C;
        read_and_check(24'h000010, 2, "read_basic");
    endtask

    task automatic test_wrap();
        mem[16'hFFFF] = 8'h11;
        mem[16'h0000] = 8'h22;
        read_and_check(24'hFFFFFF, 2, "read_wrap");
    endtask

    task automatic test_id_sr();
        logic [31:0] id_exp;
        id_exp = 32'hEF401600;
        tx_buf[0] = 8'h9F;
        for (int j = 1; j < 8; j++) tx_buf[j] = 8'($urandom);
        run_txn(40, 1'b0);
        for (int k = 0; k < 4; k++) begin
            logic [7:0] exp_b;
            exp_b = id_exp[31 - 8 * k -: 8];
            total++;
            if (rx_buf[1 + k] !== exp_b || oe_buf[1 + k] !== 8'hFF) begin
                bad++;
                $display("FAIL jedec byte%0d: got %h oe=%h expected %h oe=ff", k, rx_buf[1 + k], oe_buf[1 + k], exp_b);
            end
        end
        total++;
        if (oe_buf[0] !== 8'h0 || strobe_q.size() != 0) begin
            bad++;
            $display("FAIL jedec cmd: got oe=%h strobes=%0d expected 00 0", oe_buf[0], strobe_q.size());
        end
        tx_buf[0] = 8'h05;
        tx_buf[1] = 8'hFF;
        tx_buf[2] = 8'hFF;
        run_txn(24, 1'b0);
        total++;
        if (rx_buf[1] !== 8'h00 || rx_buf[2] !== 8'h00 || oe_buf[1] !== 8'hFF || oe_buf[2] !== 8'hFF) begin
            bad++;
            $display("FAIL rdsr: got %h %h oe=%h %h expected 00 00 oe=ff ff", rx_buf[1], rx_buf[2], oe_buf[1], oe_buf[2]);
        end
    endtask

    task automatic test_fast_read();
        tx_buf[0] = 8'h0B; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00; tx_buf[3] = 8'h04;
        tx_buf[4] = 8'($urandom);
        tx_buf[5] = 8'($urandom);
        run_txn(48, 1'b0);
`ifdef SPI_FLASH_RESP_FAST_READ_EN
        total++;
        if (rx_buf[5] !== mem[16'h0004] || oe_buf[5] !== 8'hFF || oe_buf[4] !== 8'h00) begin
            bad++;
            $display("FAIL fast_read: got %h oe=%h/%h expected %h oe=00/ff", rx_buf[5], oe_buf[4], oe_buf[5], mem[16'h0004]);
        end
        total++;
        if (strobe_q.size() != 2 || strobe_q[0] !== 32'h4 || strobe_q[1] !== 32'h5) begin
            bad++;
            $display("FAIL fast_strobes: got count=%0d expected 2 at 0004,0005", strobe_q.size());
        end
`else
        total++;
        if ({oe_buf[0], oe_buf[1], oe_buf[2], oe_buf[3], oe_buf[4], oe_buf[5]} !== 48'h0 || strobe_q.size() != 0) begin
            bad++;
            $display("FAIL fast_ignored: got oe_seen=%h%h strobes=%0d expected 0 0", oe_buf[4], oe_buf[5], strobe_q.size());
        end
`endif
    endtask

    task automatic test_abort();
        tx_buf[0] = 8'h03; tx_buf[1] = 8'h00; tx_buf[2] = 8'h5A; tx_buf[3] = 8'hC3;
        run_txn(8 + 13, 1'b0);
        total++;
        if (strobe_q.size() != 0 || oe_buf[1] !== 8'h0) begin
            bad++;
            $display("FAIL abort: got strobes=%0d oe=%h expected 0 00", strobe_q.size(), oe_buf[1]);
        end
        read_and_check(24'h000020, 2, "after_abort");
    endtask

    task automatic test_unknown_cmd();
        logic [7:0] c;
        c = 8'h03;
        for (int t = 0; t < 16 && (c == 8'h03 || c == 8'h9F || c == 8'h05 || c == 8'h0B); t++)
            c = 8'($urandom);
        if (c == 8'h03 || c == 8'h9F || c == 8'h05 || c == 8'h0B) c = 8'h5A;
        tx_buf[0] = c;
        for (int j = 1; j < 8; j++) tx_buf[j] = 8'($urandom);
        run_txn(32, 1'b0);
        total++;
        if ({oe_buf[0], oe_buf[1], oe_buf[2], oe_buf[3]} !== 32'h0 || strobe_q.size() != 0 || busy_all !== 1'b1) begin
            bad++;
            $display("FAIL unknown_%h: got strobes=%0d busy_all=%b expected no oe, 0 strobes, busy", c, strobe_q.size(), busy_all);
        end
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 6; t++) begin
            logic [23:0] a;
            a = 24'($urandom);
            read_and_check(a, 1 + int'($urandom_range(3)), "random_read");
        end
    endtask

    task automatic test_async_reset();
        mem[16'h0040] = 8'h96;
        tx_buf[0] = 8'h03; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00; tx_buf[3] = 8'h40;
        tx_buf[4] = 8'h00;
        run_txn(40, 1'b1);
        total++;
        if (rx_buf[4] !== 8'h96 || miso_oe !== 1'b1 || busy !== 1'b1 || mem_addr !== 16'h0041) begin
            bad++;
            $display("FAIL pre_reset: got %h oe=%b busy=%b addr=%h expected 96 1 1 0041", rx_buf[4], miso_oe, busy, mem_addr);
        end
        rst_ni = 1'b0;
        #1;
        total++;
        if ({miso, miso_oe, mem_rd, busy} !== 4'b0 || mem_addr !== 16'h0) begin
            bad++;
            $display("FAIL async_reset: got miso=%b oe=%b rd=%b busy=%b addr=%h expected zeros",
                     miso, miso_oe, mem_rd, busy, mem_addr);
        end
        clk_wait(3);
        rst_ni = 1'b1;
        clk_wait(4);
        run_txn(40, 1'b1);
        total++;
        if (strobe_q.size() != 0 || busy_any !== 1'b0 || oe_buf[4] !== 8'h0) begin
            bad++;
            $display("FAIL post_reset_cs_low: got strobes=%0d busy_any=%b expected 0 0", strobe_q.size(), busy_any);
        end
        cs_n = 1'b1;
        clk_wait(GAP);
        read_and_check(24'h000040, 1, "post_reset_read");
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int j = 0; j < 8; j++) tx_buf[j] = 8'h00;
        test_reset();
        test_read_basic();
        test_wrap();
        test_id_sr();
        test_fast_read();
        test_abort();
        test_unknown_cmd();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish within 2ms");
        $fatal(1, "watchdog expired");
    end

endmodule
